// File: rtl/player_instr_scheduler_if.sv
// Player instruction bus: one 16-bit word per handshake from the scheduler
// (master) to the player datapath (slave).
//
// Handshake: a transfer happens on a rising edge where instr_valid and
// instr_ready are both high. While instr_valid is high and instr_ready is
// low, the master keeps instr unchanged. instr_ready may toggle freely, and
// the slave may raise it before valid is asserted.
interface player_instr_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready
   );
endinterface

// File: rtl/player_instr_scheduler.sv
// Player instruction scheduler: arbitrates damage (via a small FIFO with
// invulnerability cooldown), heal pickups and movement keys onto the shared
// 16-bit player instruction bus. Active only while enable is high.
module player_instr_scheduler #(
   parameter int         FIFO_DEPTH    = 4,
   parameter int         IFRAME_CYCLES = 8,
   parameter logic [7:0] HEAL_AMT      = 8'd10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          dmg_req,
   input  logic [7:0]    dmg_amt,
   input  logic          heal_req,
   input  logic          mov_req,
   input  logic [1:0]    mov_dir,
   player_instr_if.master bus,
   output logic          dmg_busy,
   output logic          queue_full,
   output logic [7:0]    drop_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int CD_W  = (IFRAME_CYCLES > 0) ? $clog2(IFRAME_CYCLES + 1) : 1;

   localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(IFRAME_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   localparam logic [3:0] OP_DPY = 4'b0010;
   localparam logic [3:0] OP_HPY = 4'b0001;
   localparam logic [3:0] OP_MOV = 4'b0101;

   // Damage FIFO storage; the entry count carries an extra bit so that
   // full and empty are distinct even though the pointers wrap.
   logic [7:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             heal_pend_q, heal_pend_d;
   logic             mov_pend_q, mov_pend_d;
   logic [1:0]       mov_dir_q, mov_dir_d;
   logic [CD_W-1:0]  cooldown_q, cooldown_d;
   logic             valid_q, valid_d;
   logic [15:0]      instr_q, instr_d;
   logic [7:0]       drop_q, drop_d;

   logic             dmg_take;
   logic             push;
   logic             drop;
   logic             slot_free;
   logic             fifo_empty;
   logic             pop;
   logic             issue_heal;
   logic             issue_mov;

   // Capture and arbitration decisions. The arbiter looks only at stored
   // state, so a request never bypasses the FIFO / pending flags.
   assign dmg_take   = enable && dmg_req && (dmg_amt != 8'd0);
   assign push       = dmg_take && (count_q != CNT_FULL) && (cooldown_q == '0);
   assign drop       = dmg_take && !push;
   assign slot_free  = !valid_q || bus.instr_ready;
   assign fifo_empty = (count_q == '0);
   assign pop        = enable && slot_free && !fifo_empty;
   assign issue_heal = enable && slot_free && fifo_empty && heal_pend_q;
   assign issue_mov  = enable && slot_free && fifo_empty && !heal_pend_q && mov_pend_q;

   // Next-state computation for queue, pending flags, cooldown and output word.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      heal_pend_d = heal_pend_q;
      mov_pend_d  = mov_pend_q;
      mov_dir_d   = mov_dir_q;
      cooldown_d  = cooldown_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      drop_d      = drop_q;

      if (!enable) begin
         // Flush: drop everything queued or presented; drop_cnt survives.
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         heal_pend_d = 1'b0;
         mov_pend_d  = 1'b0;
         cooldown_d  = '0;
         valid_d     = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         if (push) begin
            cooldown_d = CD_LOAD;
         end else if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
         end

         // A request arriving on the issue edge re-arms the flag.
         heal_pend_d = (heal_pend_q && !issue_heal) || heal_req;

         if (issue_mov) begin
            mov_pend_d = 1'b0;
         end
         if (mov_req) begin
            mov_pend_d = 1'b1;
            mov_dir_d  = mov_dir;
         end

         if (slot_free) begin
            valid_d = 1'b0;
            if (pop) begin
               valid_d = 1'b1;
               instr_d = {OP_DPY, fifo_mem_q[rd_ptr_q], 4'b0000};
            end else if (issue_heal) begin
               valid_d = 1'b1;
               instr_d = {OP_HPY, HEAL_AMT, 4'b0000};
            end else if (issue_mov) begin
               valid_d = 1'b1;
               instr_d = {OP_MOV, 6'b000000, mov_dir_q, 4'b0000};
            end
         end
      end

      if (drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         heal_pend_q <= 1'b0;
         mov_pend_q  <= 1'b0;
         mov_dir_q   <= 2'b00;
         cooldown_q  <= '0;
         valid_q     <= 1'b0;
         instr_q     <= 16'h0000;
         drop_q      <= 8'h00;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         heal_pend_q <= heal_pend_d;
         mov_pend_q  <= mov_pend_d;
         mov_dir_q   <= mov_dir_d;
         cooldown_q  <= cooldown_d;
         valid_q     <= valid_d;
         instr_q     <= instr_d;
         drop_q      <= drop_d;
      end
   end

   // FIFO storage write; contents need no reset because the count gates reads.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         fifo_mem_q[wr_ptr_q] <= dmg_amt;
      end
   end

   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign dmg_busy        = !fifo_empty || (valid_q && (instr_q[15:12] == OP_DPY));
   assign queue_full      = (count_q == CNT_FULL);
   assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_player_instr_scheduler.sv
// Bench for player_instr_scheduler: two instances (cooldown 8 and cooldown 0)
// share one stimulus stream; a queue-based reference model tracks both.
module tb_player_instr_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       dmg_req = 1'b0;
   logic [7:0] dmg_amt = 8'd0;
   logic       heal_req = 1'b0;
   logic       mov_req = 1'b0;
   logic [1:0] mov_dir = 2'd0;
   logic       ready = 1'b0;

   logic       busy_a, full_a, busy_b, full_b;
   logic [7:0] drop_a, drop_b;

   int checks = 0;
   int failures = 0;

   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [15:0] got_b_q[$];

   player_instr_if bus_a ();
   player_instr_if bus_b ();
   assign bus_a.instr_ready = ready;
   assign bus_b.instr_ready = ready;

   player_instr_scheduler #(.FIFO_DEPTH(4), .IFRAME_CYCLES(8), .HEAL_AMT(8'd10)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .dmg_req(dmg_req), .dmg_amt(dmg_amt),
      .heal_req(heal_req), .mov_req(mov_req), .mov_dir(mov_dir), .bus(bus_a),
      .dmg_busy(busy_a), .queue_full(full_a), .drop_cnt(drop_a)
   );

   player_instr_scheduler #(.FIFO_DEPTH(4), .IFRAME_CYCLES(0), .HEAL_AMT(8'd10)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .dmg_req(dmg_req), .dmg_amt(dmg_amt),
      .heal_req(heal_req), .mov_req(mov_req), .mov_dir(mov_dir), .bus(bus_b),
      .dmg_busy(busy_b), .queue_full(full_b), .drop_cnt(drop_b)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model (index 0: cooldown 8, 1: cooldown 0) ----------------
   int          m_iframe[2] = '{8, 0};
   int          m_fifo[2][4];
   int          m_cnt[2];
   bit          m_heal[2];
   bit          m_mov[2];
   int          m_dir[2];
   int          m_cd[2];
   int          m_drop[2];
   bit          m_valid[2];
   logic [15:0] m_instr[2];

   function automatic void model_step();
      bit full_pre, free, pushed;
      int cd_pre;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_cnt[k] = 0; m_heal[k] = 0; m_mov[k] = 0; m_dir[k] = 0; m_cd[k] = 0;
            m_drop[k] = 0; m_valid[k] = 0; m_instr[k] = 16'h0000;
         end else if (!enable) begin
            m_cnt[k] = 0; m_heal[k] = 0; m_mov[k] = 0; m_cd[k] = 0; m_valid[k] = 0;
         end else begin
            full_pre = (m_cnt[k] == 4);
            cd_pre   = m_cd[k];
            free     = !m_valid[k] || ready;
            pushed   = 0;
            if (free) begin
               if (m_cnt[k] > 0) begin
                  m_instr[k] = {4'h2, 8'(m_fifo[k][0]), 4'h0};
                  for (int i = 0; i < 3; i++) m_fifo[k][i] = m_fifo[k][i+1];
                  m_cnt[k]--;
                  m_valid[k] = 1;
               end else if (m_heal[k]) begin
                  m_instr[k] = {4'h1, 8'd10, 4'h0};
                  m_heal[k] = 0;
                  m_valid[k] = 1;
               end else if (m_mov[k]) begin
                  m_instr[k] = {4'h5, 6'd0, 2'(m_dir[k]), 4'h0};
                  m_mov[k] = 0;
                  m_valid[k] = 1;
               end else begin
                  m_valid[k] = 0;
               end
            end
            if (dmg_req && dmg_amt != 8'd0) begin
               if (!full_pre && cd_pre == 0) begin
                  m_fifo[k][m_cnt[k]] = int'(dmg_amt);
                  m_cnt[k]++;
                  m_cd[k] = m_iframe[k];
                  pushed = 1;
               end else if (m_drop[k] < 255) begin
                  m_drop[k]++;
               end
            end
            if (!pushed && m_cd[k] > 0) m_cd[k]--;
            if (heal_req) m_heal[k] = 1;
            if (mov_req) begin
               m_mov[k] = 1;
               m_dir[k] = int'(mov_dir);
            end
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_reqs();
      dmg_req = 1'b0; dmg_amt = 8'd0; heal_req = 1'b0; mov_req = 1'b0; mov_dir = 2'd0;
   endtask

   task automatic do_reset();
      clear_reqs();
      reset = 1'b1; enable = 1'b0; ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; ready = 1'b1; dmg_req = 1'b1; dmg_amt = 8'd5; heal_req = 1'b1;
      tick(); tick();
      checks++; if (bus_a.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus_a.instr_valid); end
      checks++; if (bus_a.instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", bus_a.instr); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_a); end
      checks++; if (full_a !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full_a); end
      checks++; if (drop_a !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_a); end
      checks++; if (bus_b.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_b got=%0b exp=0", bus_b.instr_valid); end
      clear_reqs();
      reset = 1'b0; enable = 1'b0; ready = 1'b0;
   endtask

   task automatic test_single_hit();
      do_reset();
      enable = 1'b1; ready = 1'b1; dmg_req = 1'b1; dmg_amt = 8'd5;
      tick();
      clear_reqs();
      checks++; if (bus_a.instr_valid !== 1'b0) begin failures++; $display("FAIL hit_no_bypass got=%0b exp=0", bus_a.instr_valid); end
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL hit_busy_queued got=%0b exp=1", busy_a); end
      tick();
      checks++; if (bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL hit_valid got=%0b exp=1", bus_a.instr_valid); end
      checks++; if (bus_a.instr !== 16'h2050) begin failures++; $display("FAIL hit_word got=%h exp=2050", bus_a.instr); end
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL hit_busy_presented got=%0b exp=1", busy_a); end
      tick();
      checks++; if (bus_a.instr_valid !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%0b exp=0", bus_a.instr_valid); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL hit_busy_after got=%0b exp=0", busy_a); end
      checks++; if (bus_a.instr !== 16'h2050) begin failures++; $display("FAIL hit_instr_kept got=%h exp=2050", bus_a.instr); end
   endtask

   task automatic test_iframe();
      logic [15:0] g;
      do_reset();
      enable = 1'b1; ready = 1'b1;
      exp_q.delete(); got_q.delete(); got_b_q.delete();
      exp_q.push_back(16'h2110);
      exp_q.push_back(16'h2330);
      for (int c = 0; c < 16; c++) begin
         dmg_req = (c == 0 || c == 3 || c == 9);
         dmg_amt = (c == 0) ? 8'h11 : (c == 3) ? 8'h22 : (c == 9) ? 8'h33 : 8'h00;
         tick();
         if (bus_a.instr_valid) got_q.push_back(bus_a.instr);
         if (bus_b.instr_valid) got_b_q.push_back(bus_b.instr);
      end
      clear_reqs();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL iframe_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL iframe_word%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
      checks++; if (drop_a !== 8'd1) begin failures++; $display("FAIL iframe_drop got=%0d exp=1", drop_a); end
      checks++; if (got_b_q.size() != 3) begin failures++; $display("FAIL nocool_count got=%0d exp=3", got_b_q.size()); end
      checks++; if (drop_b !== 8'd0) begin failures++; $display("FAIL nocool_drop got=%0d exp=0", drop_b); end
   endtask

   task automatic test_priority();
      do_reset();
      enable = 1'b1; ready = 1'b1;
      heal_req = 1'b1; mov_req = 1'b1; mov_dir = 2'd3; dmg_req = 1'b1; dmg_amt = 8'd7;
      tick();
      clear_reqs();
      checks++; if (bus_a.instr_valid !== 1'b0) begin failures++; $display("FAIL prio_idle got=%0b exp=0", bus_a.instr_valid); end
      tick();
      checks++; if (bus_a.instr !== 16'h2070 || bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL prio_first got=%h/%0b exp=2070/1", bus_a.instr, bus_a.instr_valid); end
      tick();
      checks++; if (bus_a.instr !== 16'h10A0 || bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL prio_second got=%h/%0b exp=10a0/1", bus_a.instr, bus_a.instr_valid); end
      tick();
      checks++; if (bus_a.instr !== 16'h5030 || bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL prio_third got=%h/%0b exp=5030/1", bus_a.instr, bus_a.instr_valid); end
      tick();
      checks++; if (bus_a.instr_valid !== 1'b0) begin failures++; $display("FAIL prio_done got=%0b exp=0", bus_a.instr_valid); end
   endtask

   task automatic test_queue_full();
      logic [15:0] g;
      do_reset();
      enable = 1'b1; ready = 1'b0;
      heal_req = 1'b1;
      tick();
      clear_reqs();
      tick();
      checks++; if (bus_b.instr !== 16'h10A0 || bus_b.instr_valid !== 1'b1) begin failures++; $display("FAIL full_heal_held got=%h/%0b exp=10a0/1", bus_b.instr, bus_b.instr_valid); end
      for (int i = 1; i <= 6; i++) begin
         dmg_req = 1'b1; dmg_amt = 8'(i);
         tick();
         if (i == 3) begin
            checks++; if (full_b !== 1'b0) begin failures++; $display("FAIL full_after3 got=%0b exp=0", full_b); end
         end
         if (i == 4) begin
            checks++; if (full_b !== 1'b1) begin failures++; $display("FAIL full_after4 got=%0b exp=1", full_b); end
         end
      end
      clear_reqs();
      checks++; if (drop_b !== 8'd2) begin failures++; $display("FAIL full_drop got=%0d exp=2", drop_b); end
      checks++; if (drop_a !== 8'd5) begin failures++; $display("FAIL full_drop_cool got=%0d exp=5", drop_a); end
      exp_q.delete(); got_q.delete();
      exp_q.push_back(16'h10A0);
      exp_q.push_back(16'h2010);
      exp_q.push_back(16'h2020);
      exp_q.push_back(16'h2030);
      exp_q.push_back(16'h2040);
      ready = 1'b1;
      if (bus_b.instr_valid) got_q.push_back(bus_b.instr);
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus_b.instr_valid) got_q.push_back(bus_b.instr);
      end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL full_drain_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
         checks++; if (g !== exp_q[i]) begin failures++; $display("FAIL full_drain%0d got=%h exp=%h", i, g, exp_q[i]); end
      end
      checks++; if (full_b !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL full_empty got=%0b/%0b exp=0/0", full_b, busy_b); end
   endtask

   task automatic test_hold();
      do_reset();
      enable = 1'b1; ready = 1'b0;
      dmg_req = 1'b1; dmg_amt = 8'd9;
      tick();
      clear_reqs();
      tick();
      checks++; if (bus_a.instr !== 16'h2090 || bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL hold_present got=%h/%0b exp=2090/1", bus_a.instr, bus_a.instr_valid); end
      mov_req = 1'b1; mov_dir = 2'd0;
      tick();
      checks++; if (bus_a.instr !== 16'h2090) begin failures++; $display("FAIL hold_stable1 got=%h exp=2090", bus_a.instr); end
      mov_dir = 2'd2;
      tick();
      checks++; if (bus_a.instr !== 16'h2090 || bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL hold_stable2 got=%h/%0b exp=2090/1", bus_a.instr, bus_a.instr_valid); end
      clear_reqs();
      ready = 1'b1;
      tick();
      checks++; if (bus_a.instr !== 16'h5020 || bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL hold_mov got=%h/%0b exp=5020/1", bus_a.instr, bus_a.instr_valid); end
      tick();
      checks++; if (bus_a.instr_valid !== 1'b0) begin failures++; $display("FAIL hold_single_mov got=%0b exp=0", bus_a.instr_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      enable = 1'b1; ready = 1'b0;
      dmg_req = 1'b1; dmg_amt = 8'd3;
      tick();
      dmg_amt = 8'd4;
      tick();
      clear_reqs();
      tick();
      checks++; if (bus_a.instr_valid !== 1'b1 || drop_a !== 8'd1) begin failures++; $display("FAIL flush_setup got=%0b/%0d exp=1/1", bus_a.instr_valid, drop_a); end
      enable = 1'b0; dmg_req = 1'b1; dmg_amt = 8'd5; heal_req = 1'b1;
      tick();
      clear_reqs();
      checks++; if (bus_a.instr_valid !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0b/%0b exp=0/0", bus_a.instr_valid, busy_a); end
      checks++; if (bus_b.instr_valid !== 1'b0 || busy_b !== 1'b0 || full_b !== 1'b0) begin failures++; $display("FAIL flush_clear_b got=%0b/%0b/%0b exp=0/0/0", bus_b.instr_valid, busy_b, full_b); end
      checks++; if (drop_a !== 8'd1) begin failures++; $display("FAIL flush_drop_kept got=%0d exp=1", drop_a); end
      enable = 1'b1; ready = 1'b1;
      tick(); tick();
      checks++; if (bus_a.instr_valid !== 1'b0 || bus_b.instr_valid !== 1'b0) begin failures++; $display("FAIL flush_nothing got=%0b/%0b exp=0/0", bus_a.instr_valid, bus_b.instr_valid); end
      ready = 1'b0; dmg_req = 1'b1; dmg_amt = 8'd6;
      tick();
      clear_reqs();
      tick();
      checks++; if (bus_a.instr !== 16'h2060 || bus_a.instr_valid !== 1'b1) begin failures++; $display("FAIL flush_reissue got=%h/%0b exp=2060/1", bus_a.instr, bus_a.instr_valid); end
      reset = 1'b1; ready = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus_a.instr_valid !== 1'b0 || drop_a !== 8'd0) begin failures++; $display("FAIL reset_midhs got=%0b/%0d exp=0/0", bus_a.instr_valid, drop_a); end
   endtask

   task automatic test_saturate();
      do_reset();
      enable = 1'b1; ready = 1'b1; dmg_req = 1'b1; dmg_amt = 8'd1;
      for (int c = 0; c < 300; c++) tick();
      clear_reqs();
      checks++; if (drop_a !== 8'd255) begin failures++; $display("FAIL sat_drop got=%0d exp=255", drop_a); end
      checks++; if (drop_b !== 8'd0) begin failures++; $display("FAIL sat_drop_b got=%0d exp=0", drop_b); end
   endtask

   task automatic test_random();
      logic exp_busy_a, exp_busy_b;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 499) == 0);
         enable   = ($urandom_range(0, 24) != 0);
         dmg_req  = ($urandom_range(0, 2) == 0);
         dmg_amt  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         heal_req = ($urandom_range(0, 5) == 0);
         mov_req  = ($urandom_range(0, 3) == 0);
         mov_dir  = 2'($urandom_range(0, 3));
         ready    = ($urandom_range(0, 2) != 0);
         tick();
         exp_busy_a = (m_cnt[0] > 0) || (m_valid[0] && m_instr[0][15:12] == 4'h2);
         exp_busy_b = (m_cnt[1] > 0) || (m_valid[1] && m_instr[1][15:12] == 4'h2);
         checks++; if (bus_a.instr_valid !== m_valid[0]) begin failures++; $display("FAIL rnd_valid_a cyc=%0d got=%0b exp=%0b", c, bus_a.instr_valid, m_valid[0]); end
         checks++; if (bus_a.instr !== m_instr[0]) begin failures++; $display("FAIL rnd_instr_a cyc=%0d got=%h exp=%h", c, bus_a.instr, m_instr[0]); end
         checks++; if (busy_a !== exp_busy_a) begin failures++; $display("FAIL rnd_busy_a cyc=%0d got=%0b exp=%0b", c, busy_a, exp_busy_a); end
         checks++; if (full_a !== (m_cnt[0] == 4)) begin failures++; $display("FAIL rnd_full_a cyc=%0d got=%0b exp=%0b", c, full_a, (m_cnt[0] == 4)); end
         checks++; if (drop_a !== 8'(m_drop[0])) begin failures++; $display("FAIL rnd_drop_a cyc=%0d got=%0d exp=%0d", c, drop_a, m_drop[0]); end
         checks++; if (bus_b.instr_valid !== m_valid[1]) begin failures++; $display("FAIL rnd_valid_b cyc=%0d got=%0b exp=%0b", c, bus_b.instr_valid, m_valid[1]); end
         checks++; if (bus_b.instr !== m_instr[1]) begin failures++; $display("FAIL rnd_instr_b cyc=%0d got=%h exp=%h", c, bus_b.instr, m_instr[1]); end
         checks++; if (busy_b !== exp_busy_b) begin failures++; $display("FAIL rnd_busy_b cyc=%0d got=%0b exp=%0b", c, busy_b, exp_busy_b); end
         checks++; if (full_b !== (m_cnt[1] == 4)) begin failures++; $display("FAIL rnd_full_b cyc=%0d got=%0b exp=%0b", c, full_b, (m_cnt[1] == 4)); end
         checks++; if (drop_b !== 8'(m_drop[1])) begin failures++; $display("FAIL rnd_drop_b cyc=%0d got=%0d exp=%0d", c, drop_b, m_drop[1]); end
      end
      clear_reqs();
      reset = 1'b0;
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_single_hit();
      test_iframe();
      test_priority();
      test_queue_full();
      test_hold();
      test_flush();
      test_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
